// File: rtl/video_line_buffer_pp.sv
// Ping-pong video row buffer: a producer fills the back bank while the pixel
// path drains the front bank with flip, integer repeat and underrun reporting.
module video_line_buffer_pp #(
    parameter int COLOR_BITS      = 4,
    parameter int PIXELS_PER_WORD = 2,
    parameter int WORDS           = 512,
    parameter int REPEAT_MAX      = 4,
    localparam int DW = PIXELS_PER_WORD * 3 * COLOR_BITS,
    localparam int CW = $clog2(WORDS),
    localparam int RW = $clog2(REPEAT_MAX + 1)
) (
    input  logic                  i_master_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_start,
    input  logic [CW-1:0]         i_wr_column,
    input  logic [DW-1:0]         i_wr_data,
    input  logic                  i_wr_valid,
    input  logic                  i_wr_done,
    input  logic                  i_rd_line_start,
    input  logic                  i_rd_pixel_enable,
    input  logic                  i_rd_blank,
    input  logic [CW:0]           i_cfg_words,
    input  logic [RW-1:0]         i_cfg_repeat,
    input  logic                  i_cfg_flip,
    output logic [COLOR_BITS-1:0] o_red,
    output logic [COLOR_BITS-1:0] o_green,
    output logic [COLOR_BITS-1:0] o_blue,
    output logic                  o_line_valid,
    output logic                  o_underrun,
    output logic [7:0]            o_underrun_count,
    output logic                  o_wr_bank
);
    localparam int PXW = 3 * COLOR_BITS;
    localparam int PW  = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;

    logic [DW-1:0]         r_mem [0:2*WORDS-1];
    logic [DW-1:0]         r_rd_data;
    logic                  r_front;
    logic                  r_wr_open;
    logic                  r_back_complete;
    logic                  r_active;
    logic                  r_line_valid;
    logic                  r_underrun;
    logic [7:0]            r_underrun_count;
    logic [CW-1:0]         r_w;
    logic [PW-1:0]         r_p;
    logic [RW-1:0]         r_r;
    logic [CW:0]           r_words;
    logic [RW-1:0]         r_repeat;
    logic                  r_flip;
    logic                  r_pix_valid;
    logic [PW-1:0]         r_slot;
    logic [COLOR_BITS-1:0] r_red;
    logic [COLOR_BITS-1:0] r_green;
    logic [COLOR_BITS-1:0] r_blue;

    logic                  w_swap;
    logic                  w_advance;
    logic                  w_last_r;
    logic                  w_last_p;
    logic                  w_last_w;
    logic                  w_wr_en;
    logic [CW:0]           w_cfg_words;
    logic [RW-1:0]         w_cfg_repeat;
    logic [CW-1:0]         w_last_word;
    logic [CW-1:0]         w_rd_word;
    logic [PW-1:0]         w_slot;
    logic [PXW-1:0]        w_pix [PIXELS_PER_WORD];

    // A wr_done arriving together with the line start still counts as complete.
    assign w_swap      = i_rd_line_start & (r_back_complete | i_wr_done);
    assign w_advance   = r_active & i_rd_pixel_enable & ~i_rd_line_start;
    assign w_last_word = CW'(r_words - (CW+1)'(1));
    assign w_last_r    = (r_r == (r_repeat - RW'(1)));
    assign w_last_p    = (r_p == PW'(PIXELS_PER_WORD - 1));
    assign w_last_w    = (r_w == w_last_word);
    assign w_rd_word   = r_flip ? (w_last_word - r_w) : r_w;
    assign w_slot      = r_flip ? (PW'(PIXELS_PER_WORD - 1) - r_p) : r_p;
    assign w_wr_en     = i_wr_valid & r_wr_open & ({1'b0, i_wr_column} < (CW+1)'(WORDS));

    always_comb begin
        w_cfg_words = i_cfg_words;
        if (i_cfg_words == '0) begin
            w_cfg_words = (CW+1)'(1);
        end else if (i_cfg_words > (CW+1)'(WORDS)) begin
            w_cfg_words = (CW+1)'(WORDS);
        end
        w_cfg_repeat = i_cfg_repeat;
        if (i_cfg_repeat == '0) begin
            w_cfg_repeat = RW'(1);
        end else if (i_cfg_repeat > RW'(REPEAT_MAX)) begin
            w_cfg_repeat = RW'(REPEAT_MAX);
        end
    end

    for (genvar gi = 0; gi < PIXELS_PER_WORD; gi++) begin : g_unpack
        assign w_pix[gi] = r_rd_data[gi*PXW +: PXW];
    end

    always_ff @(posedge i_master_clk) begin
        if (w_wr_en) begin
            r_mem[{~r_front, i_wr_column}] <= i_wr_data;
        end
        r_rd_data <= r_mem[{r_front, w_rd_word}];
    end

    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_open       <= 1'b0;
            r_back_complete <= 1'b0;
        end else begin
            if (i_wr_done) begin
                r_wr_open <= 1'b0;
            end else if (i_wr_start) begin
                r_wr_open <= 1'b1;
            end
            if (w_swap) begin
                r_back_complete <= 1'b0;
            end else if (i_wr_done) begin
                r_back_complete <= 1'b1;
            end else if (i_wr_start) begin
                r_back_complete <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            r_front          <= 1'b0;
            r_line_valid     <= 1'b0;
            r_underrun       <= 1'b0;
            r_underrun_count <= 8'd0;
            r_active         <= 1'b0;
            r_w              <= '0;
            r_p              <= '0;
            r_r              <= '0;
            r_words          <= (CW+1)'(1);
            r_repeat         <= RW'(1);
            r_flip           <= 1'b0;
        end else if (i_rd_line_start) begin
            r_front      <= r_front ^ w_swap;
            r_line_valid <= w_swap;
            r_underrun   <= ~w_swap;
            if (!w_swap && r_underrun_count != 8'hFF) begin
                r_underrun_count <= r_underrun_count + 8'd1;
            end
            r_active <= 1'b1;
            r_w      <= '0;
            r_p      <= '0;
            r_r      <= '0;
            r_words  <= w_cfg_words;
            r_repeat <= w_cfg_repeat;
            r_flip   <= i_cfg_flip;
        end else begin
            r_underrun <= 1'b0;
            if (w_advance) begin
                if (!w_last_r) begin
                    r_r <= r_r + RW'(1);
                end else begin
                    r_r <= '0;
                    if (!w_last_p) begin
                        r_p <= r_p + PW'(1);
                    end else begin
                        r_p <= '0;
                        if (w_last_w) begin
                            r_w      <= '0;
                            r_active <= 1'b0;
                        end else begin
                            r_w <= r_w + CW'(1);
                        end
                    end
                end
            end
        end
    end

    // Output stage: the slot and validity travel alongside the RAM read.
    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pix_valid <= 1'b0;
            r_slot      <= '0;
            r_red       <= '0;
            r_green     <= '0;
            r_blue      <= '0;
        end else begin
            r_pix_valid <= r_active & r_line_valid;
            r_slot      <= w_slot;
            if (r_pix_valid && !i_rd_blank) begin
                {r_blue, r_green, r_red} <= w_pix[r_slot];
            end else begin
                {r_blue, r_green, r_red} <= '0;
            end
        end
    end

    assign o_red            = r_red;
    assign o_green          = r_green;
    assign o_blue           = r_blue;
    assign o_line_valid     = r_line_valid;
    assign o_underrun       = r_underrun;
    assign o_underrun_count = r_underrun_count;
    assign o_wr_bank        = ~r_front;
endmodule

// File: doc/video_line_buffer_pp.md
# video_line_buffer_pp

Parametrised, double-banked (ping-pong) video row buffer in the master clock domain. A producer (VRAM controller or video decoder) fills the back bank while the pixel output path drains the front bank. The output path supports configurable pixels per memory word, horizontal flip, integer pixel repeat (horizontal scaling) and explicit underrun reporting. It sits between the VRAM/decoder row fetch logic and the video output stage.

## Interface
Parameters:
- COLOR_BITS, 4, bits per colour channel
- PIXELS_PER_WORD, 2, pixels packed per memory word; word width DW = PIXELS_PER_WORD*3*COLOR_BITS
- WORDS, 512, words per bank; CW = clog2(WORDS)
- REPEAT_MAX, 4, maximum pixel repeat factor; RW = clog2(REPEAT_MAX+1)

Ports:
- i_master_clk  in  1  sole clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_wr_start  in  1  open the back bank for a new line; clears its complete flag
- i_wr_column  in  CW  word address within the back bank
- i_wr_data  in  DW  packed pixel word
- i_wr_valid  in  1  write strobe
- i_wr_done  in  1  mark the back bank complete and close it
- i_rd_line_start  in  1  start of a displayed line; swap/underrun decision
- i_rd_pixel_enable  in  1  advance one output pixel
- i_rd_blank  in  1  force output colour to zero
- i_cfg_words  in  CW+1  active words per line, 1..WORDS
- i_cfg_repeat  in  RW  repeat factor; 0 is treated as 1; values above REPEAT_MAX saturate
- i_cfg_flip  in  1  horizontal mirror
- o_red, o_green, o_blue  out  COLOR_BITS each  pixel colour, registered
- o_line_valid  out  1  current front line holds valid data
- o_underrun  out  1  one-cycle pulse on a line start with no complete back bank
- o_underrun_count  out  8  saturating underrun counter
- o_wr_bank  out  1  index of the current back bank

## Operation
- Storage is 2*WORDS words of DW bits. Bank address = {bank, column}. Read and write ports are independent.
- Front bank register `front`, reset value 0. o_wr_bank = ~front.
- Write side uses flags wr_open and back_complete:
  - i_wr_start: wr_open=1, back_complete=0.
  - i_wr_valid with wr_open=1 and i_wr_column < WORDS: write the word.
  - Writes while wr_open=0 are dropped.
  - i_wr_done: wr_open=0, back_complete=1.
- On i_rd_line_start:
  - If back_complete=1 (including an i_wr_done in the same cycle): front toggles, back_complete=0, o_line_valid=1.
  - Otherwise: no swap, o_line_valid=0, o_underrun pulses, and the counter increments, saturating at 255.
  - In both cases the read counters clear and the line becomes active.
  - The cfg inputs are sampled here and held for the whole line.
- i_wr_start in the same cycle as a swap applies to the new back bank, which is the old front bank.
- Read counters:
  - Word index w runs 0..words-1, pixel index p runs 0..PPW-1, repeat r runs 0..repeat-1.
  - Each i_rd_pixel_enable increments r. When r wraps, p increments. When p wraps, w increments.
  - After the last pixel (words*PPW*repeat enables) the line goes inactive and the output is 0.
- Address = flip ? words-1-w : w.
- Pixel slot k = flip ? PPW-1-p : p. Slot k occupies bits [k*3*CB +: 3*CB], ordered red (low), green, blue.
- Output is zero when i_rd_blank=1, o_line_valid=0, or the line is inactive.
- Reset: all outputs 0; front=0; wr_open=0; back_complete=0; counters 0; line inactive. Memory contents are undefined. Reset mid-line aborts both sides immediately.

## Timing
- Read latency: the colour for an enable at cycle n appears on the outputs at n+2 (registered RAM read, then output register).
- i_rd_blank is applied in the output register stage, with latency 1.
- o_underrun is asserted during cycle n+1 for a line start at cycle n.
- o_line_valid and o_wr_bank update at n+1.
- A write at cycle n becomes readable from cycle n+1.
- Enables arriving in the same cycle as i_rd_line_start are ignored.

## Test plan
- Default parameters. Fill the back bank with word i = {12'h(2i+1), 12'h(2i)}, then wr_done, line_start, 1024 enables with repeat 1 → pixel colours 12'h000, 12'h001, ..., 12'h3FF; o_line_valid=1, o_wr_bank=0.
- Same bank with flip=1 and words=4 → outputs 12'h007, 006, 005, 004, 003, 002, 001, 000, then 0.
- repeat=3, words=1, word {12'hABC, 12'h123} → 123, 123, 123, ABC, ABC, ABC, then 0.
- line_start with no wr_done → o_underrun pulse, count 1, colour 0, no bank swap. Repeat 300 times → count saturates at 255.
- wr_done and line_start in the same cycle → swap occurs and no underrun. Writes after wr_done, before the next wr_start, do not alter the memory.
- Assert i_reset mid-line during both a write and a read → all outputs 0 at once; after release, o_wr_bank=1 and o_line_valid=0.
